// File: rtl/sparse_pkg.sv
// Shared types and record formatting for the COO sparse-matrix path.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
//
// Holds the element struct, field widths, record slot offsets, the packer
// state encodings and pack_record(), which the downstream unpacker reuses so
// both ends agree on the record layout.
package sparse_pkg;

    localparam int ROW_W  = 8;
    localparam int COL_W  = 8;
    localparam int VAL_W  = 32;
    localparam int SEQ_W  = 32;
    localparam int REC_W  = 136;
    localparam int ELEM_W = 1 + ROW_W + COL_W + VAL_W;  // 49

    // Record layout: {seq, pad, slot1, slot0}
    localparam int SLOT0_LSB = 0;
    localparam int SLOT1_LSB = ELEM_W;
    localparam int PAD_LSB   = 2 * ELEM_W;
    localparam int SEQ_LSB   = REC_W - SEQ_W;

    typedef struct packed {
        logic             vld;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [VAL_W-1:0] val;
    } elem_t;

    // Packer state encodings
    localparam logic [1:0] ST_EMPTY = 2'd0;  // no element held
    localparam logic [1:0] ST_HALF  = 2'd1;  // slot0 held, waiting for partner
    localparam logic [1:0] ST_DONE  = 2'd2;  // matrix terminated by last
    localparam logic [1:0] ST_FULL  = 2'd3;  // memory capacity reached

    function automatic logic [REC_W-1:0] pack_record(
        input logic [SEQ_W-1:0] seq,
        input elem_t            s1,
        input elem_t            s0
    );
        logic [REC_W-1:0] rec;
        rec = '0;  // pad bits stay zero
        rec[SEQ_LSB   +: SEQ_W ] = seq;
        rec[SLOT1_LSB +: ELEM_W] = s1;
        rec[SLOT0_LSB +: ELEM_W] = s0;
        return rec;
    endfunction

endpackage

// File: rtl/coo_packer.sv
// Packs a COO nonzero stream two elements per 136-bit record for the record memory.
// Latency: record appears (wen=1) the cycle after the accept that completes it.
// Backpressure: in_ready depends on state only; drops to 0 once done or full.
//
// Ports: clk, resetn (sync, active-low), clear (sync restart);
//        in_valid/in_ready/in_row/in_col/in_val/in_last element input;
//        wen/inData memory write; full, done, count status.
// Optional build macro COO_PACKER_ZERO_SKIP_EN: zero-valued elements are
// accepted but not stored.
module coo_packer
    import sparse_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROW_W-1:0]           in_row,
    input  logic [COL_W-1:0]           in_col,
    input  logic [VAL_W-1:0]           in_val,
    input  logic                       in_last,
    output logic                       wen,
    output logic [REC_W-1:0]           inData,
    output logic                       full,
    output logic                       done,
    output logic [$clog2(ENTRIES):0]   count
);

    localparam int CNT_W = $clog2(ENTRIES) + 1;

    logic [1:0]       state_q, state_d;
    elem_t            slot0_q, slot0_d;
    logic             wen_q,   wen_d;
    logic [REC_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q,  done_d;

    logic  accept;
    logic  is_zero;
    logic  emit;
    elem_t cur_elem;
    elem_t rec_s1;
    elem_t rec_s0;

    // Gated by resetn so nothing is offered while reset is held.
    assign in_ready = resetn && ((state_q == ST_EMPTY) || (state_q == ST_HALF));
    assign accept   = in_valid && in_ready;

    assign cur_elem = '{vld: 1'b1, row: in_row, col: in_col, val: in_val};

`ifdef COO_PACKER_ZERO_SKIP_EN
    assign is_zero = (in_val == '0);
`else
    assign is_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        wen_d   = 1'b0;
        data_d  = data_q;   // inData holds between writes
        count_d = count_q;
        done_d  = done_q;
        emit    = 1'b0;
        rec_s1  = '0;
        rec_s0  = '0;

        if (clear) begin
            // Restart wins over a same-cycle accept; any half pair is dropped.
            state_d = ST_EMPTY;
            slot0_d = '0;
            data_d  = '0;
            count_d = '0;
            done_d  = 1'b0;
        end else if (accept) begin
            case (state_q)
                ST_EMPTY: begin
                    if (is_zero) begin
                        // Skipped zero: nothing to store; last still terminates.
                        if (in_last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (in_last) begin
                        emit    = 1'b1;
                        rec_s0  = cur_elem;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        slot0_d = cur_elem;
                        state_d = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (!(is_zero && !in_last)) begin
                        emit    = 1'b1;
                        rec_s0  = slot0_q;
                        rec_s1  = is_zero ? elem_t'('0) : cur_elem;
                        slot0_d = '0;
                        if (in_last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if (count_q == CNT_W'(ENTRIES - 1)) begin
                            state_d = ST_FULL;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Sequence number is the count before this record is counted.
        if (emit) begin
            wen_d   = 1'b1;
            data_d  = pack_record(SEQ_W'(count_q), rec_s1, rec_s0);
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            slot0_q <= '0;
            wen_q   <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            wen_q   <= wen_d;
            data_q  <= data_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign wen    = wen_q;
    assign inData = data_q;
    assign count  = count_q;
    assign done   = done_q;
    // Rises on the same edge as the final count increment, alongside its wen.
    assign full   = (count_q == CNT_W'(ENTRIES));

endmodule
